gpio_in_ctrl: RTL and testbench

//  Bus-mapped controller for a sampled GPIO input port.
//  - Schedules sampling with a programmable prescaler; debounces each bit.
//  - Detects edges and latches them into sticky pending bits that drive one interrupt line.
//  - Sits on the peripheral bus (cs/wen/addr/din/dout) beside the plain input port.

---
 rtl/gpio_in_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_gpio_in_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_ctrl.sv
// Purpose: bus-mapped sampled GPIO input port with a prescaled sample tick, per-bit debounce,
//          edge detection into sticky pending bits, and one level interrupt.
// Latency: prescale=0 and DEB_LEN=3: DATA follows io_in after 6 clocks, PEND/irq after 7; dout is combinational.
// Backpressure: none. Bus accesses complete in one cycle; io_in is sampled every cycle.
//
// Ports:
//   clk, reset_n  clock (rising edge) and asynchronous active-low reset
//   cs, wen       chip select and write enable; a write happens when cs & wen
//   addr, din     register address and write data
//   dout          read data, selected by addr alone (cs is ignored)
//   io_in         asynchronous external inputs
//   irq           OR of all pending bits
//
// Register map:
//   0 DATA (RO), 1 PRESCALE (RW), 2 RISE_EN (RW), 3 PEND (W1C),
//   4 FALL_EN (RW, only with GPIO_IN_CTRL_FALL_EN), 5 RAW (RO). Other addresses read 0.
//
// Build option: define GPIO_IN_CTRL_FALL_EN to add the FALL_EN register so that falling edges
// also set PEND. Without it, address 4 reads 0 and only rising edges are reported.

module gpio_in_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEB_LEN = 3,
    parameter int unsigned PRE_W   = 16,
    parameter int unsigned PRE_RST = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] io_in,
    output logic             irq
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_PRE  = 3'd1;
    localparam logic [2:0] A_RISE = 3'd2;
    localparam logic [2:0] A_PEND = 3'd3;
    localparam logic [2:0] A_FALL = 3'd4;
    localparam logic [2:0] A_RAW  = 3'd5;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] raw;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] cnt;
    logic             tick;
    logic [WIDTH-1:0] hist [DEB_LEN];
    logic [WIDTH-1:0] all1;
    logic [WIDTH-1:0] all0;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] pend_set;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] rise_en;

    logic bus_wr;
    logic wr_pre;
    logic wr_rise;
    logic wr_pend;

    assign bus_wr  = cs & wen;
    assign wr_pre  = bus_wr && (addr == A_PRE);
    assign wr_rise = bus_wr && (addr == A_RISE);
    assign wr_pend = bus_wr && (addr == A_PEND);

    // Two-flop synchronizer; raw is the first metastability-safe copy of io_in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            raw   <= '0;
        end else begin
            sync1 <= io_in;
            raw   <= sync1;
        end
    end

    // Prescaler. A PRESCALE write restarts the count and suppresses the tick of that
    // cycle so the new period is measured from a clean start.
    assign tick = (cnt == prescale) && !wr_pre;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= PRE_W'(PRE_RST);
            cnt      <= '0;
        end else if (wr_pre) begin
            prescale <= din[PRE_W-1:0];
            cnt      <= '0;
        end else if (tick) begin
            cnt      <= '0;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    // Unanimity across the registered history. DATA is judged against the history as it
    // stands before this tick's shift, which is what gives the extra tick of latency.
    always_comb begin
        all1 = '1;
        all0 = '1;
        for (int s = 0; s < DEB_LEN; s++) begin
            all1 = all1 & hist[s];
            all0 = all0 & ~hist[s];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < DEB_LEN; s++) begin
                hist[s] <= '0;
            end
            data <= '0;
        end else if (tick) begin
            hist[0] <= raw;
            for (int s = 1; s < DEB_LEN; s++) begin
                hist[s] <= hist[s-1];
            end
            data <= (data | all1) & ~all0;
        end
    end

    // Previous DATA, so each DATA change produces a one-cycle edge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_d <= '0;
        end else begin
            data_d <= data;
        end
    end

    assign rise = data & ~data_d;

`ifdef GPIO_IN_CTRL_FALL_EN
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] fall;
    logic             wr_fall;

    assign wr_fall  = bus_wr && (addr == A_FALL);
    assign fall     = ~data & data_d;
    assign pend_set = (rise & rise_en) | (fall & fall_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fall_en <= '0;
        end else if (wr_fall) begin
            fall_en <= din;
        end
    end
`else
    assign pend_set = rise & rise_en;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en <= '0;
        end else if (wr_rise) begin
            rise_en <= din;
        end
    end

    // Clear is applied first, so a bit being set in the same cycle as it is cleared stays set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(wr_pend ? din : '0)) | pend_set;
        end
    end

    assign irq = |pend;

    always_comb begin
        dout = '0;
        case (addr)
            A_DATA: dout = data;
            A_PRE:  dout[PRE_W-1:0] = prescale;
            A_RISE: dout = rise_en;
            A_PEND: dout = pend;
`ifdef GPIO_IN_CTRL_FALL_EN
            A_FALL: dout = fall_en;
`endif
            A_RAW:  dout = raw;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_in_ctrl.sv
module tb_gpio_in_ctrl;

`ifdef GPIO_IN_CTRL_FALL_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        wen;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] io_in;
    logic        irq;

    int total = 0;
    int bad   = 0;

    gpio_in_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .wen     (wen),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .io_in   (io_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues a write that lands on the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs   = 1'b1;
        wen  = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        cs   = 1'b0;
        wen  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] v;
    int          n;

    initial begin
        cs = 0; wen = 0; addr = 0; din = 0; io_in = 0;
        reset_n = 0;
        wait_cyc(3);

        // Reset state: everything reads zero (PRE_RST is 0), irq low.
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk($sformatf("rst_addr%0d", a), v, 32'h0);
        end
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1;
        wait_cyc(2);

        // Rising edge latency at PRESCALE=0.
        wr(3'd2, 32'h0000_0009);
        wait_cyc(4);
        io_in[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            rd(3'd0, v);
            chk($sformatf("lat_data_e%0d", e), v, (e >= 6) ? 32'h1 : 32'h0);
            rd(3'd3, v);
            chk($sformatf("lat_pend_e%0d", e), v, (e >= 7) ? 32'h1 : 32'h0);
            chk($sformatf("lat_irq_e%0d", e), {31'b0, irq}, (e >= 7) ? 32'h1 : 32'h0);
        end
        rd(3'd5, v);
        chk("raw_bit0", v, 32'h1);
        wr(3'd0, 32'hffff_ffff);
        rd(3'd0, v);
        chk("data_ro", v, 32'h1);
        wr(3'd6, 32'hffff_ffff);
        rd(3'd6, v);
        chk("unmapped_rd", v, 32'h0);
        wr(3'd3, 32'h1);
        rd(3'd3, v);
        chk("w1c_pend", v, 32'h0);
        chk("w1c_irq", {31'b0, irq}, 32'h0);

        // Two-cycle glitch on bit 3 must be filtered.
        io_in[3] = 1'b1;
        wait_cyc(2);
        io_in[3] = 1'b0;
        wait_cyc(12);
        rd(3'd0, v);
        chk("glitch_data", v, 32'h1);
        rd(3'd3, v);
        chk("glitch_pend", v, 32'h0);

        // Prescaled sampling on bit 1.
        wr(3'd1, 32'd9);
        rd(3'd1, v);
        chk("prescale_rd", v, 32'd9);
        io_in[1] = 1'b1;
        n = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            rd(3'd0, v);
            if (v[1] && n == 0) n = e;
        end
        if (n == 0) $display("FAIL pre_timeout: got DATA[1]=0 after 60 cycles, expected 1");
        chk("pre_latency_range", {31'b0, (n >= 30 && n <= 42)}, 32'h1);
        wr(3'd1, 32'd0);

        // W1C in the same cycle that a new rise sets bit 0: set wins.
        io_in[0] = 1'b0;
        wait_cyc(10);
        wr(3'd3, 32'hffff_ffff);
        rd(3'd3, v);
        chk("pre_collide_pend", v, 32'h0);
        io_in[0] = 1'b1;
        wait_cyc(6);
        wr(3'd3, 32'h1);
        rd(3'd3, v);
        chk("collide_pend", v, 32'h1);
        chk("collide_irq", {31'b0, irq}, 32'h1);
        // Disabling the enable leaves the pending bit alone.
        wr(3'd2, 32'h0);
        rd(3'd3, v);
        chk("en_change_pend", v, 32'h1);
        wr(3'd3, 32'h1);
        rd(3'd3, v);
        chk("collide_clear", v, 32'h0);

        // Falling edge on bit 2.
        io_in[2] = 1'b1;
        wait_cyc(10);
        wr(3'd3, 32'hffff_ffff);
        wr(3'd4, 32'h4);
        rd(3'd4, v);
        chk("fall_en_rd", v, FE ? 32'h4 : 32'h0);
        io_in[2] = 1'b0;
        wait_cyc(10);
        rd(3'd3, v);
        chk("fall_pend", v, FE ? 32'h4 : 32'h0);
        chk("fall_irq", {31'b0, irq}, FE ? 32'h1 : 32'h0);

        // Reset mid-run; inputs 0 and 1 still held high afterwards.
        reset_n = 1'b0;
        #1;
        rd(3'd0, v);
        chk("rst2_data", v, 32'h0);
        rd(3'd5, v);
        chk("rst2_raw", v, 32'h0);
        rd(3'd3, v);
        chk("rst2_pend", v, 32'h0);
        wait_cyc(1);
        reset_n = 1'b1;
        wr(3'd2, 32'h1);
        wait_cyc(10);
        rd(3'd0, v);
        chk("post_rst_data", v, 32'h3);
        rd(3'd3, v);
        chk("post_rst_pend", v, 32'h1);
        chk("post_rst_irq", {31'b0, irq}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
